// File: rtl/rc4_session_ctrl.sv
// ============================================================================
// rc4_session_ctrl
// ----------------------------------------------------------------------------
// Sequences one RC4 keystream core per session. A legal key command
// re-initialises the core, runs it (KSA then PRGA), buffers its keystream
// bytes in a small FIFO and serves them to a consumer over valid/ready.
//
// Valid/ready rule used on every handshake in this block: a transfer happens
// in the cycle where valid && ready are both high at the rising clock edge.
// The source holds valid and its payload steady until that transfer happens.
// The sink may raise or drop ready freely.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           session command handshake (ready in IDLE)
//   cmd_key[31:0], cmd_key_len    key (byte 0 = [7:0]) and length 1..4
//   abort                         kill the current session (ignored in IDLE)
//   core_rst_n                    synchronous active-low re-init to the core
//   core_start                    run enable to the core
//   core_key, core_key_length     latched key and length
//   core_ks_valid, core_ks_byte   keystream byte from the core
//   core_done                     core has emitted its final byte (level)
//   ks_valid/ks_ready, ks_data    keystream output handshake, FIFO head byte
//   ks_last                       ks_data is the final byte of the session
//   busy                          session in progress (state != IDLE)
//   err                           one-cycle pulse: illegal key length
//   ovf                           sticky: a byte was dropped on a full FIFO
//   dbg_state                     current FSM state encoding
// ============================================================================
module rc4_session_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int SKID       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_key,
    input  logic [7:0]  cmd_key_len,
    input  logic        abort,
    output logic        core_rst_n,
    output logic        core_start,
    output logic [31:0] core_key,
    output logic [7:0]  core_key_length,
    input  logic        core_ks_valid,
    input  logic [7:0]  core_ks_byte,
    input  logic        core_done,
    output logic        ks_valid,
    input  logic        ks_ready,
    output logic [7:0]  ks_data,
    output logic        ks_last,
    output logic        busy,
    output logic        err,
    output logic        ovf,
    output logic [2:0]  dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t         r_state, w_state_nxt;
    logic           r_hold, w_hold_nxt;   // second cycle of a 2-cycle core reset
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]  r_count, w_count_nxt;
    logic           r_core_rst_n, r_core_start, r_err, r_ovf;
    logic [31:0]    r_core_key;
    logic [7:0]     r_core_key_length;

    logic w_cmd_fire, w_len_ok, w_abort, w_full;
    logic w_push, w_pop, w_push_ok, w_push_drop, w_core_start_nxt;

    assign w_cmd_fire  = cmd_valid && (r_state == S_IDLE);
    assign w_len_ok    = (cmd_key_len != 8'd0) && (cmd_key_len <= 8'd4);
    assign w_abort     = abort && (r_state != S_IDLE);
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_pop       = ks_valid && ks_ready;
    // Abort outranks a byte arriving in the same cycle.
    assign w_push      = (r_state == S_RUN) && core_ks_valid && !w_abort;
    // A simultaneous pop frees the slot, so a push on full still lands.
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_push_drop = w_push && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_abort) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push_ok, w_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        if (w_abort) begin
            w_state_nxt = S_ABORT;
            w_hold_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire && w_len_ok) begin
                        w_state_nxt = S_INIT;
                        w_hold_nxt  = 1'b0;
                    end
                end
                S_INIT: begin
                    if (r_hold) w_state_nxt = S_RUN;
                    else        w_hold_nxt  = 1'b1;
                end
                S_RUN: begin
                    if (core_done) w_state_nxt = S_DRAIN;
                end
                S_DRAIN: begin
                    // Looking at the next count lets busy fall right after the
                    // final byte is taken, and leaves an empty DRAIN in 1 cycle.
                    if (w_count_nxt == '0) w_state_nxt = S_IDLE;
                end
                S_ABORT: begin
                    if (r_hold) w_state_nxt = S_IDLE;
                    else        w_hold_nxt  = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Registered run enable reflects the count after this edge, so it drops
    // in the same cycle the buffer reaches its reserve threshold.
    assign w_core_start_nxt = (w_state_nxt == S_RUN) &&
                              (w_count_nxt < CW'(FIFO_DEPTH - SKID));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_IDLE;
            r_hold            <= 1'b0;
            r_count           <= '0;
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_core_rst_n      <= 1'b0;
            r_core_start      <= 1'b0;
            r_core_key        <= '0;
            r_core_key_length <= '0;
            r_err             <= 1'b0;
            r_ovf             <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_count      <= w_count_nxt;
            r_core_rst_n <= !((w_state_nxt == S_INIT) || (w_state_nxt == S_ABORT));
            r_core_start <= w_core_start_nxt;
            r_err        <= w_cmd_fire && !w_len_ok;
            if (w_abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_cmd_fire && w_len_ok) begin
                r_core_key        <= cmd_key;
                r_core_key_length <= cmd_key_len;
                r_ovf             <= 1'b0;
            end else if (w_push_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage needs no reset: ks_valid gates every read.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= core_ks_byte;
    end

    assign cmd_ready       = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);
    assign ks_valid        = (r_count != '0);
    assign ks_data         = r_mem[r_rd_ptr];
    assign ks_last         = ks_valid && (r_state == S_DRAIN) && (r_count == CW'(1));
    assign core_rst_n      = r_core_rst_n;
    assign core_start      = r_core_start;
    assign core_key        = r_core_key;
    assign core_key_length = r_core_key_length;
    assign err             = r_err;
    assign ovf             = r_ovf;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_rc4_session_ctrl.sv
module tb_rc4_session_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_key;
    logic [7:0]  cmd_key_len;
    logic        abort;
    logic        core_rst_n;
    logic        core_start;
    logic [31:0] core_key;
    logic [7:0]  core_key_length;
    logic        core_ks_valid;
    logic [7:0]  core_ks_byte;
    logic        core_done;
    logic        ks_valid;
    logic        ks_ready;
    logic [7:0]  ks_data;
    logic        ks_last;
    logic        busy;
    logic        err;
    logic        ovf;
    logic [2:0]  dbg_state;

    rc4_session_ctrl #(.FIFO_DEPTH(8), .SKID(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_key         (cmd_key),
        .cmd_key_len     (cmd_key_len),
        .abort           (abort),
        .core_rst_n      (core_rst_n),
        .core_start      (core_start),
        .core_key        (core_key),
        .core_key_length (core_key_length),
        .core_ks_valid   (core_ks_valid),
        .core_ks_byte    (core_ks_byte),
        .core_done       (core_done),
        .ks_valid        (ks_valid),
        .ks_ready        (ks_ready),
        .ks_data         (ks_data),
        .ks_last         (ks_last),
        .busy            (busy),
        .err             (err),
        .ovf             (ovf),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Each entry is {last_tag, byte}.
    logic [8:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_last   = 0;
    logic [31:0] exp_key = 32'h0;
    logic [7:0]  exp_len = 8'h0;

    typedef struct {
        logic [31:0] key;
        logic [7:0]  len;
        logic        exp_err;
    } cmd_vec_t;
    cmd_vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: score the consumer side before the edge, then advance to
    // 1ns past the edge where registered outputs are stable.
    task automatic cycle();
        logic [8:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : 9'h0;
        if (ks_valid) begin
            check("ks_last", {31'h0, ks_last}, {31'h0, head[8]});
        end else begin
            check("ks_last_idle", {31'h0, ks_last}, 32'h0);
        end
        if (ks_valid && ks_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {24'h0, ks_data}, 32'hFFFF_FFFF);
            end else begin
                head = exp_q.pop_front();
                check("ks_data", {24'h0, ks_data}, {24'h0, head[7:0]});
            end
            if (ks_last) n_last++;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [31:0] key, input logic [7:0] len);
        cmd_valid   = 1'b1;
        cmd_key     = key;
        cmd_key_len = len;
        cycle();
        cmd_valid = 1'b0;
        if (len != 8'd0 && len <= 8'd4) begin
            exp_key = key;
            exp_len = len;
        end
    endtask

    task automatic start_session(input logic [31:0] key, input logic [7:0] len);
        send_cmd(key, len);
        cycle();
        cycle();
    endtask

    task automatic drive_core(input logic v, input logic [7:0] b, input logic done,
                              input logic store);
        core_ks_valid = v;
        core_ks_byte  = b;
        core_done     = done;
        if (store) exp_q.push_back({done, b});
        cycle();
        core_ks_valid = 1'b0;
        core_done     = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            cycle();
            k++;
        end
        check("drain_done_busy", {31'h0, busy}, 32'h0);
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{key: 32'h1122_3344, len: 8'd0,   exp_err: 1'b1};
        vecs[1] = '{key: 32'h5566_7788, len: 8'd5,   exp_err: 1'b1};
        vecs[2] = '{key: 32'h99AA_BBCC, len: 8'hFF,  exp_err: 1'b1};
        vecs[3] = '{key: 32'hDEAD_BEEF, len: 8'd1,   exp_err: 1'b0};
        vecs[4] = '{key: 32'h0403_0201, len: 8'd4,   exp_err: 1'b0};
        vecs[5] = '{key: 32'hCAFE_F00D, len: 8'd3,   exp_err: 1'b0};

        rst_n = 1'b1;
        cmd_valid = 1'b0; cmd_key = '0; cmd_key_len = '0; abort = 1'b0;
        core_ks_valid = 1'b0; core_ks_byte = '0; core_done = 1'b0; ks_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        // reset values, before any clock edge
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_core_rst_n", {31'h0, core_rst_n}, 32'h0);
        check("rst_core_start", {31'h0, core_start}, 32'h0);
        check("rst_core_key", core_key, 32'h0);
        check("rst_core_key_length", {24'h0, core_key_length}, 32'h0);
        check("rst_ks_valid", {31'h0, ks_valid}, 32'h0);
        check("rst_ks_last", {31'h0, ks_last}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_ovf", {31'h0, ovf}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_core_rst_n", {31'h0, core_rst_n}, 32'h1);

        // command table: illegal lengths pulse err, legal ones enter INIT
        for (int i = 0; i < 6; i++) begin
            check("tbl_cmd_ready", {31'h0, cmd_ready}, 32'h1);
            send_cmd(vecs[i].key, vecs[i].len);
            check("tbl_err", {31'h0, err}, {31'h0, vecs[i].exp_err});
            check("tbl_busy", {31'h0, busy}, {31'h0, !vecs[i].exp_err});
            check("tbl_core_rst_n", {31'h0, core_rst_n}, {31'h0, vecs[i].exp_err});
            check("tbl_core_key", core_key, exp_key);
            check("tbl_core_key_length", {24'h0, core_key_length}, {24'h0, exp_len});
            cycle();
            check("tbl_err_pulse", {31'h0, err}, 32'h0);
            if (!vecs[i].exp_err) begin
                abort = 1'b1;
                cycle();
                abort = 1'b0;
                check("tbl_abort_rst_n", {31'h0, core_rst_n}, 32'h0);
                check("tbl_abort_busy", {31'h0, busy}, 32'h1);
                cycle();
                cycle();
                check("tbl_abort_idle", {31'h0, busy}, 32'h0);
            end else begin
                check("tbl_illegal_rst_n", {31'h0, core_rst_n}, 32'h1);
            end
        end

        // 6-byte session streamed straight through
        ks_ready = 1'b1;
        n_last = 0;
        send_cmd(32'h0403_0201, 8'd4);
        check("s1_init_rst_n_a", {31'h0, core_rst_n}, 32'h0);
        check("s1_init_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        cycle();
        check("s1_init_rst_n_b", {31'h0, core_rst_n}, 32'h0);
        check("s1_init_start", {31'h0, core_start}, 32'h0);
        cycle();
        check("s1_run_rst_n", {31'h0, core_rst_n}, 32'h1);
        check("s1_run_start", {31'h0, core_start}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            drive_core(1'b1, 8'hA0 + 8'(i), (i == 5), 1'b1);
            if (i == 0) check("s1_no_fallthrough", {31'h0, ks_valid}, 32'h1);
        end
        check("s1_last_valid", {31'h0, ks_last}, 32'h1);
        check("s1_last_data", {24'h0, ks_data}, 32'hA5);
        check("s1_drain_start", {31'h0, core_start}, 32'h0);
        cycle();
        check("s1_busy_fall", {31'h0, busy}, 32'h0);
        check("s1_ovf", {31'h0, ovf}, 32'h0);
        check("s1_n_last", n_last, 1);
        check("s1_q_empty", exp_q.size(), 0);

        // fill: run enable falls at 6 entries, full drop sets ovf
        ks_ready = 1'b0;
        n_last = 0;
        start_session(32'h1357_9BDF, 8'd2);
        for (int i = 1; i <= 8; i++) begin
            drive_core(1'b1, 8'h30 + 8'(i), 1'b0, 1'b1);
            check("s3_core_start", {31'h0, core_start}, {31'h0, (i < 6)});
        end
        check("s3_ovf_before", {31'h0, ovf}, 32'h0);
        drive_core(1'b1, 8'h39, 1'b0, 1'b0);
        check("s3_ovf_after", {31'h0, ovf}, 32'h1);
        ks_ready = 1'b1;
        drive_core(1'b1, 8'h3A, 1'b1, 1'b1);
        check("s3_ovf_kept", {31'h0, ovf}, 32'h1);
        drain(20);
        check("s3_q_empty", exp_q.size(), 0);
        check("s3_n_last", n_last, 1);
        check("s3_ovf_sticky", {31'h0, ovf}, 32'h1);

        // abort 3 cycles into RUN with 2 bytes buffered
        ks_ready = 1'b0;
        n_last = 0;
        send_cmd(32'h2468_ACE0, 8'd4);
        check("s4_ovf_cleared", {31'h0, ovf}, 32'h0);
        cycle();
        cycle();
        drive_core(1'b1, 8'h41, 1'b0, 1'b1);
        drive_core(1'b1, 8'h42, 1'b0, 1'b1);
        check("s4_buffered", {31'h0, ks_valid}, 32'h1);
        abort = 1'b1;
        drive_core(1'b1, 8'hEE, 1'b1, 1'b0);
        abort = 1'b0;
        exp_q.delete();
        check("s4_ks_valid", {31'h0, ks_valid}, 32'h0);
        check("s4_busy", {31'h0, busy}, 32'h1);
        check("s4_rst_n_a", {31'h0, core_rst_n}, 32'h0);
        check("s4_start", {31'h0, core_start}, 32'h0);
        ks_ready = 1'b1;
        cycle();
        check("s4_rst_n_b", {31'h0, core_rst_n}, 32'h0);
        check("s4_ks_valid_b", {31'h0, ks_valid}, 32'h0);
        cycle();
        check("s4_idle", {31'h0, busy}, 32'h0);
        check("s4_rst_n_rel", {31'h0, core_rst_n}, 32'h1);
        check("s4_n_last", n_last, 0);

        // abort in IDLE is ignored and the command is still taken
        abort = 1'b1;
        send_cmd(32'h0000_00AB, 8'd1);
        abort = 1'b0;
        check("idle_abort_cmd_taken", {31'h0, busy}, 32'h1);
        check("idle_abort_key", core_key, 32'h0000_00AB);
        cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        cycle();
        cycle();
        check("idle_abort_back", {31'h0, busy}, 32'h0);

        // DRAIN with 5 bytes, consumer toggling ready
        ks_ready = 1'b0;
        n_last = 0;
        start_session(32'h5555_AAAA, 8'd4);
        for (int i = 1; i <= 5; i++) drive_core(1'b1, 8'h50 + 8'(i), (i == 5), 1'b1);
        check("s5_count_start", {31'h0, ks_valid}, 32'h1);
        for (int k = 0; k < 30 && busy; k++) begin
            logic [7:0] held;
            logic       stall;
            ks_ready = (k % 2 == 0);
            stall = ks_valid && !ks_ready;
            held  = ks_data;
            cycle();
            if (stall) check("s5_data_stable", {24'h0, ks_data}, {24'h0, held});
        end
        check("s5_idle", {31'h0, busy}, 32'h0);
        check("s5_q_empty", exp_q.size(), 0);
        check("s5_n_last", n_last, 1);

        // core_done with an empty FIFO: one DRAIN cycle, no ks_last
        ks_ready = 1'b1;
        n_last = 0;
        start_session(32'h0F0F_0F0F, 8'd2);
        drive_core(1'b0, 8'h00, 1'b1, 1'b0);
        check("s_empty_busy", {31'h0, busy}, 32'h1);
        check("s_empty_ks_valid", {31'h0, ks_valid}, 32'h0);
        check("s_empty_start", {31'h0, core_start}, 32'h0);
        cycle();
        check("s_empty_idle", {31'h0, busy}, 32'h0);
        check("s_empty_n_last", n_last, 0);

        // async reset mid-RUN
        ks_ready = 1'b0;
        start_session(32'h7777_1111, 8'd4);
        drive_core(1'b1, 8'h61, 1'b0, 1'b1);
        drive_core(1'b1, 8'h62, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("s6_busy", {31'h0, busy}, 32'h0);
        check("s6_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("s6_core_rst_n", {31'h0, core_rst_n}, 32'h0);
        check("s6_core_start", {31'h0, core_start}, 32'h0);
        check("s6_core_key", core_key, 32'h0);
        check("s6_core_key_length", {24'h0, core_key_length}, 32'h0);
        check("s6_ks_valid", {31'h0, ks_valid}, 32'h0);
        check("s6_ks_last", {31'h0, ks_last}, 32'h0);
        check("s6_err", {31'h0, err}, 32'h0);
        check("s6_ovf", {31'h0, ovf}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("s6_recover", {31'h0, core_rst_n}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
